// File: rtl/pipe_reg_skid.sv
// Elastic pipeline register: main + one-entry skid, registered ready/valid.
// Optional PIPE_REG_SKID_FLUSH_EN adds a flush port that empties the stage.
module pipe_reg_skid #(
  parameter int unsigned      SIZE        = 32,
  parameter logic [SIZE-1:0]  RESET_VALUE = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SIZE-1:0] out,
  output logic            out_valid,
  input  logic            out_ready
`ifdef PIPE_REG_SKID_FLUSH_EN
  ,
  input  logic            flush
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state;
  logic [SIZE-1:0] main_q;
  logic [SIZE-1:0] skid_q;
  logic            in_fire;
  logic            out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out      = main_q;

  // in_ready/out_valid are flops kept in step with state,
  // so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= EMPTY;
      main_q    <= RESET_VALUE;
      skid_q    <= RESET_VALUE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end
`ifdef PIPE_REG_SKID_FLUSH_EN
    else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end
`endif
    else begin
      unique case (state)
        EMPTY: begin
          if (in_valid) begin
            main_q    <= in;
            state     <= BUSY;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= in;
          end else if (in_fire) begin
            skid_q   <= in;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (out_fire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q   <= skid_q;
            state    <= BUSY;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed bench for pipe_reg_skid (SIZE=8, RESET_VALUE=8'hA5).
// Flush scenario is built only with PIPE_REG_SKID_FLUSH_EN.
module tb_pipe_reg_skid;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d_out;
  logic       out_valid;
  logic       out_ready;
`ifdef PIPE_REG_SKID_FLUSH_EN
  logic       flush;
`endif

  int vec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  pipe_reg_skid #(
    .SIZE(8),
    .RESET_VALUE(8'hA5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in(d_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out(d_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef PIPE_REG_SKID_FLUSH_EN
    ,
    .flush(flush)
`endif
  );

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; d_in = 8'h11; out_ready = 1'b0;
    edge1();
    edge1();
    vec++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL reset_valid got %b want 0", out_valid);
    end
    vec++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL reset_ready got %b want 1", in_ready);
    end
    vec++;
    if (d_out !== 8'hA5) begin
      errs++; $display("FAIL reset_out got %h want a5", d_out);
    end
    reset = 1'b1; in_valid = 1'b0;
    edge1();
    vec++;
    if (out_valid !== 1'b0 || d_out !== 8'hA5) begin
      errs++;
      $display("FAIL reset_release got v=%b o=%h want v=0 o=a5",
               out_valid, d_out);
    end
  endtask

  task automatic test_stream();
    logic [7:0] words [3];
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_in = words[i]; in_valid = 1'b1;
      edge1();
      vec++;
      if (out_valid !== 1'b1 || d_out !== words[i] || in_ready !== 1'b1) begin
        errs++;
        $display("FAIL stream_%0d got v=%b o=%h r=%b want v=1 o=%h r=1",
                 i, out_valid, d_out, in_ready, words[i]);
      end
    end
    in_valid = 1'b0;
    edge1();
    vec++;
    if (out_valid !== 1'b0 || d_out !== 8'h03) begin
      errs++;
      $display("FAIL stream_end got v=%b o=%h want v=0 o=03",
               out_valid, d_out);
    end
  endtask

  task automatic test_skid();
    out_ready = 1'b0; in_valid = 1'b1; d_in = 8'h10;
    edge1();
    d_in = 8'h20;
    edge1();
    vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || d_out !== 8'h10) begin
      errs++;
      $display("FAIL skid_full got r=%b v=%b o=%h want r=0 v=1 o=10",
               in_ready, out_valid, d_out);
    end
    d_in = 8'h30;
    edge1();
    vec++;
    if (in_ready !== 1'b0 || d_out !== 8'h10) begin
      errs++;
      $display("FAIL skid_hold got r=%b o=%h want r=0 o=10",
               in_ready, d_out);
    end
    out_ready = 1'b1;
    edge1();
    vec++;
    if (out_valid !== 1'b1 || d_out !== 8'h20 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL skid_pop1 got v=%b o=%h r=%b want v=1 o=20 r=1",
               out_valid, d_out, in_ready);
    end
    edge1();
    vec++;
    if (out_valid !== 1'b1 || d_out !== 8'h30) begin
      errs++;
      $display("FAIL skid_pop2 got v=%b o=%h want v=1 o=30",
               out_valid, d_out);
    end
    in_valid = 1'b0;
    edge1();
    vec++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL skid_empty got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_drain();
    out_ready = 1'b0; in_valid = 1'b1; d_in = 8'hA1;
    edge1();
    d_in = 8'hA2;
    edge1();
    in_valid = 1'b0; out_ready = 1'b1;
    vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errs++;
      $display("FAIL drain_0 got v=%b r=%b want v=1 r=0",
               out_valid, in_ready);
    end
    edge1();
    vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || d_out !== 8'hA2) begin
      errs++;
      $display("FAIL drain_1 got v=%b r=%b o=%h want v=1 r=1 o=a2",
               out_valid, in_ready, d_out);
    end
    edge1();
    vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL drain_2 got v=%b r=%b want v=0 r=1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; d_in = 8'h44;
    edge1();
    d_in = 8'h55;
    edge1();
    reset = 1'b0; in_valid = 1'b0;
    edge1();
    vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || d_out !== 8'hA5) begin
      errs++;
      $display("FAIL rstmid got v=%b r=%b o=%h want v=0 r=1 o=a5",
               out_valid, in_ready, d_out);
    end
    reset = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge1();
      vec++;
      if (out_valid !== 1'b0) begin
        errs++;
        $display("FAIL rstmid_quiet_%0d got v=%b o=%h want v=0",
                 i, out_valid, d_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    // one stall cycle mid-stream must not cost an input slot
    out_ready = 1'b1; in_valid = 1'b1; d_in = 8'hB0;
    edge1();
    out_ready = 1'b0; d_in = 8'hB1;
    edge1();
    vec++;
    if (in_ready !== 1'b0 || d_out !== 8'hB0) begin
      errs++;
      $display("FAIL b2b_stall got r=%b o=%h want r=0 o=b0",
               in_ready, d_out);
    end
    out_ready = 1'b1; d_in = 8'hB2;
    edge1();
    vec++;
    if (d_out !== 8'hB1 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL b2b_1 got o=%h r=%b want o=b1 r=1", d_out, in_ready);
    end
    edge1();
    vec++;
    if (d_out !== 8'hB2 || out_valid !== 1'b1) begin
      errs++;
      $display("FAIL b2b_2 got o=%h v=%b want o=b2 v=1", d_out, out_valid);
    end
    in_valid = 1'b0;
    edge1();
  endtask

`ifdef PIPE_REG_SKID_FLUSH_EN
  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; d_in = 8'h66;
    edge1();
    vec++;
    if (out_valid !== 1'b1 || d_out !== 8'h66) begin
      errs++;
      $display("FAIL flush_busy got v=%b o=%h want v=1 o=66",
               out_valid, d_out);
    end
    flush = 1'b1; d_in = 8'h77;
    edge1();
    vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL flush_empty got v=%b r=%b want v=0 r=1",
               out_valid, in_ready);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      edge1();
      vec++;
      if (out_valid !== 1'b0 || d_out !== 8'h66) begin
        errs++;
        $display("FAIL flush_quiet_%0d got v=%b o=%h want v=0 o=66",
                 i, out_valid, d_out);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b0; d_in = '0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef PIPE_REG_SKID_FLUSH_EN
    flush = 1'b0;
`endif
    test_reset();
    test_stream();
    test_skid();
    test_drain();
    test_reset_mid();
    test_back_to_back();
`ifdef PIPE_REG_SKID_FLUSH_EN
    test_flush();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
